// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO controllers.
//   - default geometry (FIFO_SIZE, FIFO_DEPTH) and pointer width (FIFO_PTR_W)
//   - default almost_full / almost_empty thresholds
//   - fifo_status_t and fifo_level_status(), which maps an entry count to
//     full/empty/almost flags (shared with the async FIFO controller)
package fifo_pkg;

   localparam int unsigned FIFO_SIZE      = 4;
   localparam int unsigned FIFO_DEPTH     = 1 << FIFO_SIZE;
   localparam int unsigned FIFO_PTR_W     = FIFO_SIZE + 1;
   localparam int unsigned FIFO_AF_THRESH = 12;
   localparam int unsigned FIFO_AE_THRESH = 4;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

   function automatic fifo_status_t fifo_level_status(
      input logic [31:0] lvl,
      input int unsigned depth,
      input int unsigned af_thresh,
      input int unsigned ae_thresh
   );
      fifo_status_t st;
      st.full         = (lvl == depth);
      st.empty        = (lvl == 32'd0);
      st.almost_full  = (lvl >= af_thresh);
      st.almost_empty = (lvl <= ae_thresh);
      return st;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: binary pointer counter with increment enable.
//   The MSB is the wrap bit; the counter rolls over modulo 2**PTR_W.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointer -> 0)
//   inc    in   advance the pointer by one on the next rising edge
//   ptr    out  current pointer value (registered)
module fifo_ptr #(
   parameter int unsigned PTR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q + PTR_W'(inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock controller for a registered-read FIFO memory.
//   Owns write/read pointers, drives memory enables/addresses, and reports
//   occupancy status. All status decodes straight from the pointer flops.
//   Optional feature macro FIFO_SYNC_CTRL_ERR_FLAGS_EN adds sticky
//   overflow/underflow flags with a clear input.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   wr_req, rd_req       producer write / consumer read request
//   mem_write_en         write strobe to memory (accepted write)
//   mem_wr_addr          memory write address
//   mem_read_en          read strobe to memory (accepted read)
//   mem_rd_addr          memory read address
//   rd_valid             memory data_out holds the previous cycle's read
//   full, empty          no free / no stored entries
//   almost_full          level >= AF_THRESH
//   almost_empty         level <= AE_THRESH
//   level                stored entry count, 0..DEPTH
//   err_clr              (macro only) clears overflow/underflow
//   overflow, underflow  (macro only) sticky write-when-full / read-when-empty
module fifo_sync_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned SIZE      = FIFO_SIZE,
   parameter int unsigned DEPTH     = FIFO_DEPTH,
   parameter int unsigned AF_THRESH = FIFO_AF_THRESH,
   parameter int unsigned AE_THRESH = FIFO_AE_THRESH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_req,
   input  logic            rd_req,
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
   input  logic            err_clr,
   output logic            overflow,
   output logic            underflow,
`endif
   output logic            mem_write_en,
   output logic [SIZE-1:0] mem_wr_addr,
   output logic            mem_read_en,
   output logic [SIZE-1:0] mem_rd_addr,
   output logic            rd_valid,
   output logic            full,
   output logic            empty,
   output logic            almost_full,
   output logic            almost_empty,
   output logic [SIZE:0]   level
);

   // Parameter sanity, caught when the design is elaborated for simulation.
   if (DEPTH != (1 << SIZE)) begin : g_bad_depth
      $error("fifo_sync_ctrl: DEPTH (%0d) must equal 2**SIZE", DEPTH);
   end
   if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH < DEPTH))) begin : g_bad_thresh
      $error("fifo_sync_ctrl: need 0 < AE_THRESH < AF_THRESH < DEPTH");
   end

   localparam int unsigned PTR_W = SIZE + 1;

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] level_w;
   fifo_status_t     status;
   logic             wr_acc;
   logic             rd_acc;
   logic             rd_valid_q;
   logic             rd_valid_d;

   // Pointer difference modulo 2**PTR_W is the occupancy; the wrap bit
   // separates full (diff == DEPTH) from empty (diff == 0).
   always_comb begin
      level_w    = wptr - rptr;
      status     = fifo_level_status(32'(level_w), DEPTH, AF_THRESH, AE_THRESH);
      wr_acc     = wr_req & ~status.full;
      rd_acc     = rd_req & ~status.empty;
      rd_valid_d = rd_acc;
   end

   fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_acc),
      .ptr   (wptr)
   );

   fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_acc),
      .ptr   (rptr)
   );

   // Memory read is registered, so data follows the accepted read by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
      end
   end

   assign mem_write_en = wr_acc;
   assign mem_wr_addr  = wptr[SIZE-1:0];
   assign mem_read_en  = rd_acc;
   assign mem_rd_addr  = rptr[SIZE-1:0];
   assign rd_valid     = rd_valid_q;
   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign level        = level_w;

`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
   logic overflow_q;
   logic overflow_d;
   logic underflow_q;
   logic underflow_d;
   logic ovf_set;
   logic udf_set;

   // A new error event in the clearing cycle keeps the flag set.
   always_comb begin
      ovf_set     = wr_req & status.full;
      udf_set     = rd_req & status.empty;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (ovf_set) begin
         overflow_d = 1'b1;
      end
      if (udf_set) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule
